des_decrypt_iter: RTL and testbench
===================================

// Module: des_decrypt_iter
// PURPOSE
//  Iterative DES decryption core: inverse cipher for the 64-bit DES datapath.
//  Applies the 16 Feistel rounds with subkeys K16..K1 and reuses the s1..s8 S-box
//  instances (f-function) across rounds, ROUNDS_PER_CLK rounds per clock.
//  Sits on the receive side of the link; consumes ciphertext/key, emits plaintext.
// PARAMETERS
//  ROUNDS_PER_CLK  1  Feistel rounds per clock; legal values 1,2,4,8,16
//                     (other values are an elaboration error).
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   ct/key are valid
//  in_ready   out  1   core can accept a block
//  ct         in   64  ciphertext, bit 63 = DES bit 1
//  key        in   64  DES key incl. parity bits (parity ignored), bit 63 = DES bit 1
//  out_valid  out  1   pt is valid
//  out_ready  in   1   downstream accepts pt
//  pt         out  64  plaintext, bit 63 = DES bit 1
//  busy       out  1   block in flight (RUN or DONE)
// BEHAVIOUR
//  - Reset (async on rst_n low): state=IDLE, in_ready=0 while rst_n low, then 1;
//    out_valid=0, busy=0, pt=0, round counter=0, all L/R/C/D registers=0.
//  - States: IDLE -> RUN on in_valid&in_ready; RUN -> DONE when the last round
//    completes; DONE -> IDLE on out_valid&out_ready.
//  - in_ready=1 only in IDLE. ct/key are sampled on the accept edge only; later
//    changes to ct/key are ignored.
//  - Accept edge: L,R = IP(ct); C,D = PC-1(key). No rotation for the first round
//    (C0,D0 already yield K16).
//  - Each round: subkey = PC-2(C,D); R' = L ^ P(S(E(R) ^ subkey)); L' = R.
//    S-box row = {b5,b0} and column = b4..b1 of each 6-bit chunk, chunk 1 -> s1.
//  - Key rotation is RIGHT, applied after each round's subkey is used.
//    Amount by round index 1..15: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
//  - Latency: 16/ROUNDS_PER_CLK clocks in RUN. out_valid rises on the edge that
//    ends the final RUN cycle. With ROUNDS_PER_CLK=1, an accept at edge 0 gives
//    out_valid=1 after edge 16.
//  - pt = FP({R16,L16}) (swap before the final permutation).
//    pt is registered and held stable while out_valid=1 && !out_ready.
//  - out_valid drops on the edge where out_valid&out_ready; in_ready rises on the
//    same edge. No same-cycle re-accept: throughput is one block per
//    16/ROUNDS_PER_CLK+2 clocks minimum.
//  - Round counter: 4-bit, wraps to 0 on entering DONE. No overflow is possible.
//  - rst_n asserted mid-RUN or in DONE: block discarded, no out_valid, all
//    registers return to reset values immediately.
//  - in_valid in RUN/DONE is ignored; the source must hold it until in_ready.
// TESTING
//  1. Reset: rst_n=0 with random inputs -> out_valid=0, busy=0, pt=0;
//     after release in_ready=1 on the first clk.
//  2. Known answer: key=133457799BBCDFF1, ct=85E813540F0AB405
//     -> pt=0123456789ABCDEF, out_valid exactly 16 clks after accept (RPC=1).
//  3. Backpressure: out_ready=0 for 10 clks in DONE -> pt/out_valid held,
//     in_ready=0, a new in_valid is not accepted.
//  4. Mid-run reset: drop rst_n at round 7 -> outputs at reset values;
//     next block decrypts correctly.
//  5. Round-trip: 1000 random key/pt, ct from the reference encryptor
//     -> pt matches for ROUNDS_PER_CLK=1,4,16; latencies 16,4,1.
//  6. Input hold: change ct/key during RUN -> result still that of the values
//     sampled at accept.

Source files
------------

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core: ROUNDS_PER_CLK Feistel rounds per clock,
// subkeys K16..K1 generated on the fly by right-rotating the PC-1 halves.
module des_decrypt_iter #(
    parameter int ROUNDS_PER_CLK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ct,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] pt,
    output logic        busy
);

    generate
        if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2 && ROUNDS_PER_CLK != 4 &&
            ROUNDS_PER_CLK != 8 && ROUNDS_PER_CLK != 16) begin : g_bad_rpc
            $error("des_decrypt_iter: ROUNDS_PER_CLK must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [4:0] RPC5    = 5'(ROUNDS_PER_CLK);

    // Tables use DES bit numbering (1 = MSB); vector index is width - n.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) res[63-i] = x[64-IP_T[i]];
        return res;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) res[63-i] = x[64-FP_T[i]];
        return res;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] res;
        res = '0;
        for (int i = 0; i < 56; i++) res[55-i] = x[64-PC1_T[i]];
        return res;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] res;
        res = '0;
        for (int i = 0; i < 48; i++) res[47-i] = x[56-PC2_T[i]];
        return res;
    endfunction

    function automatic logic [47:0] expand_e(input logic [31:0] x);
        logic [47:0] res;
        res = '0;
        for (int i = 0; i < 48; i++) res[47-i] = x[32-E_T[i]];
        return res;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) res[31-i] = x[32-P_T[i]];
        return res;
    endfunction

    // f-function: s1 takes the most significant 6-bit chunk.
    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  b;
        x = expand_e(r) ^ k;
        s = '0;
        for (int n = 0; n < 8; n++) begin
            b = x[47-6*n -: 6];
            s[31-4*n -: 4] = 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
        end
        return perm_p(s);
    endfunction

    logic [1:0]  state_q;
    logic [3:0]  cnt_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [63:0] pt_q;

    logic [31:0] l_n, r_n, tmp_r;
    logic [27:0] c_n, d_n;
    logic [4:0]  rnd;
    logic        last_step;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; the source holds valid and data stable until that edge.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign pt        = pt_q;
    assign last_step = (({1'b0, cnt_q} + RPC5) == 5'd16);

    // Rounds of one clock, chained; rnd is the 1-based decryption round index.
    always_comb begin
        l_n   = l_q;
        r_n   = r_q;
        c_n   = c_q;
        d_n   = d_q;
        tmp_r = '0;
        rnd   = '0;
        for (int j = 0; j < ROUNDS_PER_CLK; j++) begin
            rnd   = {1'b0, cnt_q} + 5'(j) + 5'd1;
            tmp_r = l_n ^ f_func(r_n, perm_pc2({c_n, d_n}));
            l_n   = r_n;
            r_n   = tmp_r;
            if (rnd == 5'd1 || rnd == 5'd8 || rnd == 5'd15) begin
                c_n = {c_n[0], c_n[27:1]};
                d_n = {d_n[0], d_n[27:1]};
            end else begin
                c_n = {c_n[1:0], c_n[27:2]};
                d_n = {d_n[1:0], d_n[27:2]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            pt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= perm_ip(ct);
                        {c_q, d_q} <= perm_pc1(key);
                        cnt_q      <= '0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    l_q <= l_n;
                    r_q <= r_n;
                    c_q <= c_n;
                    d_q <= d_n;
                    if (last_step) begin
                        pt_q    <= perm_fp({r_n, l_n});
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + RPC5[3:0];
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: three instances (1, 4, 16 rounds/clk) checked
// against a bit-level DES encryption reference model.
module tb_des_decrypt_iter;

    localparam int NU = 3;
    localparam int EXP_LAT [NU] = '{16, 4, 1};
    localparam int RPC_V [NU]   = '{1, 4, 16};

    localparam int TB_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int TB_FP [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int TB_E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int TB_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int TB_LSHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int TB_S [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

    // ---------------- clock / reset / signals ----------------
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] ct;
    logic [63:0] key;
    logic        out_ready;
    logic        in_ready_v  [NU];
    logic        out_valid_v [NU];
    logic        busy_v      [NU];
    logic [63:0] pt_v        [NU];

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    des_decrypt_iter #(.ROUNDS_PER_CLK(1)) u_rpc1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .ct(ct), .key(key), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .pt(pt_v[0]), .busy(busy_v[0]));
    des_decrypt_iter #(.ROUNDS_PER_CLK(4)) u_rpc4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .ct(ct), .key(key), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .pt(pt_v[1]), .busy(busy_v[1]));
    des_decrypt_iter #(.ROUNDS_PER_CLK(16)) u_rpc16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .ct(ct), .key(key), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .pt(pt_v[2]), .busy(busy_v[2]));

    // ---------------- reference model ----------------
    // Textbook DES encryption on 1-based bit arrays (bit 1 = MSB).
    function automatic logic [63:0] ref_encrypt(input logic [63:0] ptx, input logic [63:0] k64);
        bit m [1:64];
        bit k [1:64];
        bit c [1:28];
        bit d [1:28];
        bit sub [1:16][1:48];
        bit l [1:32];
        bit r [1:32];
        bit nr [1:32];
        bit er [1:48];
        bit so [1:32];
        bit pre [1:64];
        bit tc, td;
        int idx, row, col, v;
        logic [63:0] res;
        for (int n = 1; n <= 64; n++) begin
            m[n] = ptx[64-n];
            k[n] = k64[64-n];
        end
        for (int i = 1; i <= 28; i++) begin
            c[i] = k[TB_PC1[i-1]];
            d[i] = k[TB_PC1[i+27]];
        end
        for (int rd = 1; rd <= 16; rd++) begin
            for (int s = 0; s < TB_LSHIFT[rd-1]; s++) begin
                tc = c[1];
                td = d[1];
                for (int i = 1; i <= 27; i++) begin
                    c[i] = c[i+1];
                    d[i] = d[i+1];
                end
                c[28] = tc;
                d[28] = td;
            end
            for (int i = 1; i <= 48; i++) begin
                idx = TB_PC2[i-1];
                sub[rd][i] = (idx <= 28) ? c[idx] : d[idx-28];
            end
        end
        for (int i = 1; i <= 32; i++) begin
            l[i] = m[TB_IP[i-1]];
            r[i] = m[TB_IP[i+31]];
        end
        for (int rd = 1; rd <= 16; rd++) begin
            for (int i = 1; i <= 48; i++) er[i] = r[TB_E[i-1]] ^ sub[rd][i];
            for (int g = 0; g < 8; g++) begin
                row = 2 * int'(er[6*g+1]) + int'(er[6*g+6]);
                col = 8 * int'(er[6*g+2]) + 4 * int'(er[6*g+3]) +
                      2 * int'(er[6*g+4]) + int'(er[6*g+5]);
                v = TB_S[g][row*16+col];
                for (int b = 0; b < 4; b++) so[4*g+1+b] = bit'((v >> (3 - b)) & 1);
            end
            for (int i = 1; i <= 32; i++) nr[i] = l[i] ^ so[TB_P[i-1]];
            for (int i = 1; i <= 32; i++) begin
                l[i] = r[i];
                r[i] = nr[i];
            end
        end
        for (int i = 1; i <= 32; i++) begin
            pre[i]    = r[i];
            pre[i+32] = l[i];
        end
        res = '0;
        for (int i = 1; i <= 64; i++) res[64-i] = pre[TB_FP[i-1]];
        return res;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Feed one block, scramble ct/key after the accept edge, measure latency,
    // optionally stall the output for 'stall' cycles, then drain it.
    task automatic run_block(input logic [63:0] k, input logic [63:0] c,
                             input logic [63:0] exp, input int stall);
        int   lat  [NU];
        bit   seen [NU];
        int   cyc;
        bit   all_seen;
        logic [63:0] e;
        exp_q.push_back(exp);
        key      = k;
        ct       = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ct       = rand64();
        key      = rand64();
        for (int u = 0; u < NU; u++) begin
            lat[u]  = 0;
            seen[u] = 1'b0;
        end
        cyc      = 0;
        all_seen = 1'b0;
        while (!all_seen && cyc < 40) begin
            tick();
            cyc++;
            all_seen = 1'b1;
            for (int u = 0; u < NU; u++) begin
                if (!seen[u] && out_valid_v[u]) begin
                    seen[u] = 1'b1;
                    lat[u]  = cyc;
                end
                if (!seen[u]) all_seen = 1'b0;
            end
        end
        e = exp_q.pop_front();
        for (int u = 0; u < NU; u++) begin
            check($sformatf("pt_rpc%0d", RPC_V[u]), pt_v[u], e);
            check($sformatf("latency_rpc%0d", RPC_V[u]), 64'(lat[u]), 64'(EXP_LAT[u]));
        end
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            ct       = rand64();
            key      = rand64();
            tick();
            for (int u = 0; u < NU; u++) begin
                check($sformatf("stall_pt_rpc%0d", RPC_V[u]), pt_v[u], e);
                check($sformatf("stall_valid_rpc%0d", RPC_V[u]), 64'(out_valid_v[u]), 64'd1);
                check($sformatf("stall_in_ready_rpc%0d", RPC_V[u]), 64'(in_ready_v[u]), 64'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (stall > 0) begin
            for (int u = 0; u < NU; u++) begin
                check($sformatf("drain_valid_rpc%0d", RPC_V[u]), 64'(out_valid_v[u]), 64'd0);
                check($sformatf("drain_in_ready_rpc%0d", RPC_V[u]), 64'(in_ready_v[u]), 64'd1);
                check($sformatf("drain_pt_rpc%0d", RPC_V[u]), pt_v[u], e);
            end
        end
        check("idle_after_drain", 64'({busy_v[0], busy_v[1], busy_v[2]}), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int u = 0; u < NU; u++) begin
            check($sformatf("%s_valid_rpc%0d", tag, RPC_V[u]), 64'(out_valid_v[u]), 64'd0);
            check($sformatf("%s_busy_rpc%0d", tag, RPC_V[u]), 64'(busy_v[u]), 64'd0);
            check($sformatf("%s_pt_rpc%0d", tag, RPC_V[u]), pt_v[u], 64'd0);
            check($sformatf("%s_in_ready_rpc%0d", tag, RPC_V[u]), 64'(in_ready_v[u]), 64'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] k, p;

        // Reset with random inputs toggling.
        rst_n     = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        ct        = rand64();
        key       = rand64();
        for (int i = 0; i < 3; i++) begin
            tick();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            ct        = rand64();
            key       = rand64();
            #1;
            check_reset_outputs("reset");
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
        for (int u = 0; u < NU; u++)
            check($sformatf("release_in_ready_rpc%0d", RPC_V[u]), 64'(in_ready_v[u]), 64'd1);

        // Known-answer block.
        run_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0);

        // Backpressure: 10 stalled cycles with a competing in_valid.
        k = rand64();
        p = rand64();
        run_block(k, ref_encrypt(p, k), p, 10);

        // Mid-run reset around round 7 of the one-round-per-clock instance.
        k = rand64();
        p = rand64();
        key      = k;
        ct       = ref_encrypt(p, k);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check("midrun_busy_rpc1", 64'(busy_v[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        tick();
        rst_n = 1'b1;
        tick();
        for (int u = 0; u < NU; u++)
            check($sformatf("midrun_release_rpc%0d", RPC_V[u]), 64'(in_ready_v[u]), 64'd1);
        run_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0);

        // Random round-trip blocks.
        for (int n = 0; n < 1000; n++) begin
            k = rand64();
            p = rand64();
            run_block(k, ref_encrypt(p, k), p, (n % 97 == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
